// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder: one BLOCK-bit segment resolved per register stage, valid/ready handshake.
// Optional build macro CSA_SATURATE_EN clamps the sum to the signed range on overflow.
module pipelined_carry_select_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NSEG = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (BLOCK < 2)) begin : g_bad_cfg
        $error("pipelined_carry_select_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end

    // The whole pipe moves as one; a full output register with no consumer freezes every stage.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int BW_IN = WIDTH - k * BLOCK;

        // acc carries resolved sum bits below segment k and still-unresolved a bits above it.
        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] acc_d;
        logic [WIDTH-1:0] acc_q;
        logic [BW_IN-1:0] b_in;
        logic             c_in;
        logic             v_in;
        logic [BLOCK:0]   sum_c0;
        logic [BLOCK:0]   sum_c1;
        logic [BLOCK:0]   seg_sum;
        logic             valid_q;
        logic             carry_q;

        if (k == 0) begin : g_head
            assign acc_in = a;
            assign b_in   = b;
            assign c_in   = cin;
            assign v_in   = in_valid;
        end else begin : g_link
            assign acc_in = g_stage[k-1].acc_q;
            assign b_in   = g_stage[k-1].g_fwd.b_hi_q;
            assign c_in   = g_stage[k-1].carry_q;
            assign v_in   = g_stage[k-1].valid_q;
        end

        assign sum_c0  = {1'b0, acc_in[k*BLOCK +: BLOCK]} + {1'b0, b_in[BLOCK-1:0]};
        assign sum_c1  = sum_c0 + {{BLOCK{1'b0}}, 1'b1};
        assign seg_sum = c_in ? sum_c1 : sum_c0;

        always_comb begin
            acc_d                     = acc_in;
            acc_d[k*BLOCK +: BLOCK]   = seg_sum[BLOCK-1:0];
        end

        // NOTE: the datapath registers are reset too, so sum/cout/of read 0 the moment rst_n falls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                acc_q   <= '0;
                carry_q <= 1'b0;
            end else if (advance) begin
                valid_q <= v_in;
                acc_q   <= acc_d;
                carry_q <= seg_sum[BLOCK];
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [BW_IN-BLOCK-1:0] b_hi_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_hi_q <= '0;
                end else if (advance) begin
                    b_hi_q <= b_in[BW_IN-1:BLOCK];
                end
            end
        end

        if (k == NSEG - 1) begin : g_tail
            logic of_q;

            // Overflow: operands agree in sign but the raw sum does not.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    of_q <= 1'b0;
                end else if (advance) begin
                    of_q <= (acc_in[WIDTH-1] == b_in[BW_IN-1]) &&
                            (seg_sum[BLOCK-1] != acc_in[WIDTH-1]);
                end
            end
        end
    end

    logic [WIDTH-1:0] raw_sum;

    assign out_valid = g_stage[NSEG-1].valid_q;
    assign raw_sum   = g_stage[NSEG-1].acc_q;
    assign cout      = g_stage[NSEG-1].carry_q;
    assign of        = g_stage[NSEG-1].g_tail.of_q;

`ifdef CSA_SATURATE_EN
    // On overflow the raw MSB is the opposite of the operand sign, which picks the clamp direction.
    always_comb begin
        sum = raw_sum;
        if (of) begin
            sum = raw_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder: arithmetic reference, per-cycle compare, directed cases.
// Honours CSA_SATURATE_EN the same way as the design.
module tb_pipelined_carry_select_adder;

    localparam int W    = 32;
    localparam int BLK  = 8;
    localparam int NSEG = W / BLK;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         of;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         of;

    pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .of        (of)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    res_t got_q[$];
    bit   m_v[NSEG];
    res_t m_r[NSEG];

    // Plain arithmetic reference for one operand set.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        res_t       r;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.of   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
`ifdef CSA_SATURATE_EN
        if (r.of) r.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return r;
    endfunction

    function automatic res_t lit(input logic [W-1:0] s, input logic c, input logic o);
        res_t r;
        r.sum  = s;
        r.cout = c;
        r.of   = o;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return 32'h7fffffff;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference pipe: NSEG slots that shift together whenever the output slot is empty or consumed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) m_v[k] <= 1'b0;
        end else if (!m_v[NSEG-1] || out_ready) begin
            m_v[0] <= in_valid;
            m_r[0] <= model(a, b, cin);
            for (int k = 1; k < NSEG; k++) begin
                m_v[k] <= m_v[k-1];
                m_r[k] <= m_r[k-1];
            end
        end
    end

    // Per-cycle compare, sampled mid-cycle.
    always @(negedge clk) begin
        check("in_ready", in_ready, !m_v[NSEG-1] || out_ready);
        check("out_valid", out_valid, m_v[NSEG-1]);
        if (m_v[NSEG-1]) begin
            check("sum", sum, m_r[NSEG-1].sum);
            check("cout", cout, m_r[NSEG-1].cout);
            check("of", of, m_r[NSEG-1].of);
        end else if (!rst_n) begin
            check("reset_outputs", {sum, cout, of}, '0);
        end
        if (out_valid && out_ready) got_q.push_back({sum, cout, of});
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        bit hs     = 1'b0;
        int budget = 40;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        while (!hs && budget > 0) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            budget--;
        end
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready never seen high for a=%h b=%h", x, y);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int budget = 60;
        while (got_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check("result_count", got_q.size(), n);
    endtask

    task automatic expect_next(input string name, input res_t exp);
        res_t r;
        if (got_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no result expected %h/%0d/%0d", name, exp.sum, exp.cout, exp.of);
        end else begin
            r = got_q.pop_front();
            check({name, "_sum"}, r.sum, exp.sum);
            check({name, "_cout"}, r.cout, exp.cout);
            check({name, "_of"}, r.of, exp.of);
        end
    endtask

    logic [W-1:0] sa[5];
    logic [W-1:0] sb[5];
    logic         sc[5];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_sum", sum, 0);
        check("reset_flags", {cout, of}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Signed overflow, positive operands.
        send(32'h7fffffff, 32'h7fffffff, 1'b0);
        wait_results(1);
`ifdef CSA_SATURATE_EN
        expect_next("pos_ovf", lit(32'h7fffffff, 1'b0, 1'b1));
`else
        expect_next("pos_ovf", lit(32'hfffffffe, 1'b0, 1'b1));
`endif

        // Signed overflow, negative operands.
        send(32'h8fffffff, 32'h8fffffff, 1'b0);
        wait_results(1);
`ifdef CSA_SATURATE_EN
        expect_next("neg_ovf", lit(32'h80000000, 1'b1, 1'b1));
`else
        expect_next("neg_ovf", lit(32'h1ffffffe, 1'b1, 1'b1));
`endif

        send(32'hffffffff, 32'hffffffff, 1'b0);
        wait_results(1);
        expect_next("minus_two", lit(32'hfffffffe, 1'b1, 1'b0));

        // Back-to-back, unstalled.
        send(32'h000007aa, 32'hffffffff, 1'b0);
        send(32'h000000af, 32'h000000af, 1'b1);
        send(32'h00000000, 32'hffffffff, 1'b0);
        wait_results(3);
        expect_next("b2b_0", lit(32'h000007a9, 1'b1, 1'b0));
        expect_next("b2b_1", lit(32'h0000015f, 1'b0, 1'b0));
        expect_next("b2b_2", lit(32'hffffffff, 1'b0, 1'b0));

        // Consumer stalls for 6 cycles while 5 sets are offered.
        for (int i = 0; i < 5; i++) begin
            sa[i] = pick();
            sb[i] = pick();
            sc[i] = 1'($urandom);
        end
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(sa[i], sb[i], sc[i]);
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_results(5);
        for (int i = 0; i < 5; i++) expect_next("stall_order", model(sa[i], sb[i], sc[i]));

        // Reset with work in flight.
        got_q.delete();
        send(32'h11111111, 32'h22222222, 1'b0);
        send(32'h33333333, 32'h44444444, 1'b1);
        send(32'h55555555, 32'h66666666, 1'b0);
        @(posedge clk);
        #1;
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_sum", sum, 0);
        check("async_reset_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h00000123, 32'hfffff123, 1'b0);
        wait_results(1);
        expect_next("post_reset", lit(32'hfffff246, 1'b0, 1'b0));
        repeat (8) @(posedge clk);
        #1;
        check("no_stale", got_q.size(), 0);

        // Random traffic with random back-pressure; the per-cycle compare does the checking.
        repeat (600) begin
            in_valid  = ($urandom % 4) != 0;
            a         = pick();
            b         = pick();
            cin       = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NSEG + 4) @(posedge clk);
        #1;
        check("drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
